// File: rtl/text_writer.sv
// Cursor-driven text writer for the character display RAM.
// Turns char/cursor commands into single-cycle RAM writes.
module text_writer #(
  parameter int COLS = 48,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_cmd,
  input  logic [7:0] in_data,
  output logic [9:0] ram_Adr,
  output logic [7:0] ram_Data,
  output logic       write_Ram,
  output logic [3:0] cur_row,
  output logic [5:0] cur_col
);

  localparam logic [2:0] PUTC   = 3'd0;
  localparam logic [2:0] HEX    = 3'd1;
  localparam logic [2:0] CR     = 3'd2;
  localparam logic [2:0] LF     = 3'd3;
  localparam logic [2:0] CLS    = 3'd4;
  localparam logic [2:0] SETCOL = 3'd5;
  localparam logic [2:0] SETROW = 3'd6;
  localparam logic [2:0] NOP    = 3'd7;

  localparam logic [5:0] LAST = 6'(COLS - 1);
  localparam logic [6:0] WID  = 7'(COLS);

  typedef enum logic [1:0] {
    IDLE,
    HEX_LO,
    CLEAR
  } state_t;

  state_t     state;
  logic [3:0] row;
  logic [5:0] col;
  logic [3:0] lo;
  logic [9:0] clr;

  assign in_ready = (state == IDLE);
  assign cur_row  = row;
  assign cur_col  = col;

  function automatic logic [7:0] hex_ascii(input logic [3:0] d);
    if (d < 4'd10) return 8'h30 + {4'd0, d};
    else           return 8'h37 + {4'd0, d};
  endfunction

  // {row, col} of the position after the current one
  function automatic logic [9:0] adv(
    input logic [3:0] r,
    input logic [5:0] c
  );
    if (c < LAST) return {r, c + 6'd1};
    else          return {r + 4'd1, 6'd0};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      lo        <= '0;
      clr       <= '0;
      write_Ram <= 1'b0;
      ram_Adr   <= '0;
      ram_Data  <= '0;
    end else begin
      write_Ram <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            unique case (in_cmd)
              PUTC: begin
                write_Ram  <= 1'b1;
                ram_Adr    <= {row, col};
                ram_Data   <= in_data;
                {row, col} <= adv(row, col);
              end
              HEX: begin
                write_Ram  <= 1'b1;
                ram_Adr    <= {row, col};
                ram_Data   <= hex_ascii(in_data[7:4]);
                {row, col} <= adv(row, col);
                lo         <= in_data[3:0];
                state      <= HEX_LO;
              end
              CR: col <= '0;
              LF: begin
                col <= '0;
                row <= row + 4'd1;
              end
              CLS: begin
                write_Ram <= 1'b1;
                ram_Adr   <= '0;
                ram_Data  <= FILL_CHAR;
                clr       <= 10'd1;
                state     <= CLEAR;
              end
              SETCOL: begin
                if ({1'b0, in_data[5:0]} >= WID) col <= LAST;
                else                             col <= in_data[5:0];
              end
              SETROW: row <= in_data[3:0];
              NOP: ;
            endcase
          end
        end
        HEX_LO: begin
          write_Ram  <= 1'b1;
          ram_Adr    <= {row, col};
          ram_Data   <= hex_ascii(lo);
          {row, col} <= adv(row, col);
          state      <= IDLE;
        end
        CLEAR: begin
          write_Ram <= 1'b1;
          ram_Adr   <= clr;
          ram_Data  <= FILL_CHAR;
          clr       <= clr + 10'd1;
          if (clr == 10'd1023) begin
            row   <= '0;
            col   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer.
// Inputs driven on negedge, outputs sampled 1ns after posedge.
module tb_text_writer;

  localparam logic [2:0] PUTC   = 3'd0;
  localparam logic [2:0] HEX    = 3'd1;
  localparam logic [2:0] CR     = 3'd2;
  localparam logic [2:0] LF     = 3'd3;
  localparam logic [2:0] CLS    = 3'd4;
  localparam logic [2:0] SETCOL = 3'd5;
  localparam logic [2:0] SETROW = 3'd6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_cmd;
  logic [7:0] in_data;
  logic [9:0] ram_Adr;
  logic [7:0] ram_Data;
  logic       write_Ram;
  logic [3:0] cur_row;
  logic [5:0] cur_col;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_writer #(.COLS(48), .FILL_CHAR(8'h20)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cmd    (in_cmd),
    .in_data   (in_data),
    .ram_Adr   (ram_Adr),
    .ram_Data  (ram_Data),
    .write_Ram (write_Ram),
    .cur_row   (cur_row),
    .cur_col   (cur_col)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // one-cycle command; returns sampled 1ns after the accepting edge
  task automatic send(input logic [2:0] c, input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_cmd   = c;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int n;
  int bad;
  logic rdy_first;

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_cmd   = PUTC;
    in_data  = 8'h55;
    repeat (3) step();
    check("rst_we", 32'(write_Ram), 0);
    check("rst_adr", 32'(ram_Adr), 0);
    check("rst_data", 32'(ram_Data), 0);
    check("rst_row", 32'(cur_row), 0);
    check("rst_col", 32'(cur_col), 0);
    check("rst_rdy", 32'(in_ready), 1);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    send(PUTC, 8'h41);
    check("putc_we", 32'(write_Ram), 1);
    check("putc_adr", 32'(ram_Adr), 0);
    check("putc_data", 32'(ram_Data), 32'h41);
    check("putc_cur", {cur_row, cur_col}, {4'd0, 6'd1});
    check("putc_rdy", 32'(in_ready), 1);
    step();
    check("putc_we_off", 32'(write_Ram), 0);

    send(SETROW, 8'd3);
    check("setrow_we", 32'(write_Ram), 0);
    check("setrow", 32'(cur_row), 3);
    send(SETCOL, 8'd47);
    check("setcol47", 32'(cur_col), 47);
    send(PUTC, 8'h5A);
    check("wrap_adr", 32'(ram_Adr), 239);
    check("wrap_data", 32'(ram_Data), 32'h5A);
    check("wrap_cur", {cur_row, cur_col}, {4'd4, 6'd0});

    send(SETROW, 8'd15);
    send(SETCOL, 8'd47);
    send(PUTC, 8'h5A);
    check("wrap15_adr", 32'(ram_Adr), 1007);
    check("wrap15_cur", {cur_row, cur_col}, {4'd0, 6'd0});

    send(SETROW, 8'd2);
    send(SETCOL, 8'd5);
    send(HEX, 8'h3C);
    check("hex_hi_we", 32'(write_Ram), 1);
    check("hex_hi_adr", 32'(ram_Adr), 133);
    check("hex_hi_data", 32'(ram_Data), 32'h33);
    check("hex_hi_rdy", 32'(in_ready), 0);
    step();
    check("hex_lo_we", 32'(write_Ram), 1);
    check("hex_lo_adr", 32'(ram_Adr), 134);
    check("hex_lo_data", 32'(ram_Data), 32'h43);
    check("hex_lo_rdy", 32'(in_ready), 1);
    check("hex_cur", {cur_row, cur_col}, {4'd2, 6'd7});
    step();
    check("hex_we_off", 32'(write_Ram), 0);

    send(HEX, 8'hF9);
    check("hexF_data", 32'(ram_Data), 32'h46);
    step();
    check("hex9_data", 32'(ram_Data), 32'h39);

    send(SETCOL, 8'd60);
    check("clamp_col", 32'(cur_col), 47);
    check("clamp_we", 32'(write_Ram), 0);
    send(CR, 8'h00);
    check("cr_col", 32'(cur_col), 0);
    check("cr_we", 32'(write_Ram), 0);
    send(SETROW, 8'd15);
    send(SETCOL, 8'd9);
    send(LF, 8'h00);
    check("lf_cur", {cur_row, cur_col}, {4'd0, 6'd0});
    check("lf_we", 32'(write_Ram), 0);

    send(SETROW, 8'd6);
    send(SETCOL, 8'd12);
    @(negedge clk);
    in_valid = 1'b1;
    in_cmd   = CLS;
    in_data  = 8'h00;
    step();
    in_cmd  = PUTC;
    in_data = 8'h58;
    n = 0;
    bad = 0;
    rdy_first = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      if (write_Ram) begin
        if (ram_Adr != 10'(n) || ram_Data != 8'h20) bad++;
        if (n == 0) rdy_first = in_ready;
        n++;
      end
      if (in_ready) break;
      step();
    end
    check("cls_count", n, 1024);
    check("cls_order", bad, 0);
    check("cls_rdy_low", 32'(rdy_first), 0);
    check("cls_rdy_end", 32'(in_ready), 1);
    check("cls_cur", {cur_row, cur_col}, {4'd0, 6'd0});
    step();
    in_valid = 1'b0;
    check("cls_next_we", 32'(write_Ram), 1);
    check("cls_next_adr", 32'(ram_Adr), 0);
    check("cls_next_data", 32'(ram_Data), 32'h58);
    check("cls_next_cur", {cur_row, cur_col}, {4'd0, 6'd1});

    send(SETROW, 8'd9);
    send(CLS, 8'h00);
    n = 1;
    for (int i = 0; i < 200 && n < 100; i++) begin
      step();
      if (write_Ram) n++;
    end
    check("rcls_writes", n, 100);
    reset_n = 1'b0;
    #1;
    check("rcls_we", 32'(write_Ram), 0);
    n = 0;
    repeat (3) begin
      step();
      if (write_Ram) n++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      step();
      if (write_Ram) n++;
    end
    check("rcls_nowrite", n, 0);
    check("rcls_rdy", 32'(in_ready), 1);
    check("rcls_cur", {cur_row, cur_col}, {4'd0, 6'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
